mem_bus_decoder: RTL and testbench

Parametrised address decoder and response multiplexer between the picorv32 native memory bus and N memory-mapped slaves (SRAM, GPIO, UART, WS2812B, future peripherals). It replaces the hard-coded select/OR-ready/rdata-mux logic in the SoC top with a per-slave base/mask table. It adds three things the flat decoder lacks: a registered per-transaction grant, an error response for unmapped addresses, and a watchdog timeout for slaves that never assert ready. Error events are counted and the faulting address is captured for debug.

---
 rtl/mem_bus_decoder.sv | 183 ++++++++++++++++++
 tb/tb_mem_bus_decoder.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_decoder.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_decoder
// Purpose  : Address decoder and response multiplexer between the picorv32
//            native memory bus and NUM_SLAVES memory-mapped slaves. Each slave
//            is matched with a base/mask pair. The grant is registered per
//            transaction. Unmapped addresses get an error response. A
//            watchdog answers with an error when the granted slave never
//            raises ready. Error events are counted and the faulting address
//            is kept for debug.
// Ports    : clk, reset_n (sync, active-low)
//            mem_valid/addr/wdata/wstrb -> CPU request
//            mem_ready/rdata            <- CPU response
//            s_sel/addr/wdata/wstrb     -> slave request (one-hot select)
//            s_ready/s_rdata            <- per-slave response
//            bus_err, err_count, err_addr -> error reporting
// Revision : 1.0 - initial release
// ============================================================================
module mem_bus_decoder #(
    parameter int                       NUM_SLAVES     = 4,
    parameter logic [32*NUM_SLAVES-1:0] SLAVE_BASE     = {32'h80001000, 32'h80000008,
                                                          32'h80000000, 32'h00000000},
    parameter logic [32*NUM_SLAVES-1:0] SLAVE_MASK     = {32'hFFFFF800, 32'hFFFFFFF8,
                                                          32'hFFFFFFFC, 32'hFFFFC000},
    parameter int                       TIMEOUT_CYCLES = 255,
    parameter logic [31:0]              ERR_RDATA      = 32'hDEADBEEF
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       mem_valid,
    input  logic [31:0]                mem_addr,
    input  logic [31:0]                mem_wdata,
    input  logic [3:0]                 mem_wstrb,
    output logic                       mem_ready,
    output logic [31:0]                mem_rdata,
    output logic [NUM_SLAVES-1:0]      s_sel,
    output logic [31:0]                s_addr,
    output logic [31:0]                s_wdata,
    output logic [3:0]                 s_wstrb,
    input  logic [NUM_SLAVES-1:0]      s_ready,
    input  logic [32*NUM_SLAVES-1:0]   s_rdata,
    output logic                       bus_err,
    output logic [15:0]                err_count,
    output logic [31:0]                err_addr
);

    localparam int c_IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int c_CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_TIMEOUT = c_CNT_W'(TIMEOUT_CYCLES);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ACTIVE = 2'd1;
    localparam logic [1:0] c_ST_ERR    = 2'd2;

    logic [1:0]            r_state_q,     w_state_d;
    logic [c_IDX_W-1:0]    r_grant_q,     w_grant_d;
    logic [NUM_SLAVES-1:0] r_sel_q,       w_sel_d;
    logic [c_CNT_W-1:0]    r_cnt_q,       w_cnt_d;
    logic [15:0]           r_err_count_q, w_err_count_d;
    logic [31:0]           r_err_addr_q,  w_err_addr_d;

    logic                  w_hit;
    logic [c_IDX_W-1:0]    w_hit_idx;
    logic                  w_gnt_ready;
    logic [31:0]           w_gnt_rdata;
    logic [c_CNT_W-1:0]    w_cnt_inc;

    // Scan from the top index down so the lowest matching slave wins.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((mem_addr & SLAVE_MASK[i*32 +: 32]) == SLAVE_BASE[i*32 +: 32]) begin
                w_hit     = 1'b1;
                w_hit_idx = c_IDX_W'(i);
            end
        end
    end

    // Only the granted slave's response is observed; others are ignored.
    assign w_gnt_ready = s_ready[r_grant_q];
    assign w_gnt_rdata = s_rdata[32*r_grant_q +: 32];
    assign w_cnt_inc   = r_cnt_q + 1'b1;

    always_comb begin
        w_state_d     = r_state_q;
        w_grant_d     = r_grant_q;
        w_sel_d       = r_sel_q;
        w_cnt_d       = r_cnt_q;
        w_err_count_d = r_err_count_q;
        w_err_addr_d  = r_err_addr_q;
        case (r_state_q)
            c_ST_IDLE: begin
                if (mem_valid) begin
                    if (w_hit) begin
                        w_state_d = c_ST_ACTIVE;
                        w_grant_d = w_hit_idx;
                        w_sel_d   = {{(NUM_SLAVES-1){1'b0}}, 1'b1} << w_hit_idx;
                        w_cnt_d   = '0;
                    end else begin
                        w_state_d = c_ST_ERR;
                    end
                end
            end
            c_ST_ACTIVE: begin
                // Abort has top priority, then completion; ready beats a
                // timeout expiring in the same cycle.
                if (!mem_valid || w_gnt_ready) begin
                    w_state_d = c_ST_IDLE;
                    w_sel_d   = '0;
                end else if ((TIMEOUT_CYCLES != 0) && (w_cnt_inc == c_TIMEOUT)) begin
                    w_state_d = c_ST_ERR;
                    w_sel_d   = '0;
                end else begin
                    w_cnt_d = w_cnt_inc;
                end
            end
            c_ST_ERR: begin
                // The CPU holds mem_addr until ready, so it is still the
                // faulting address here; logging on exit makes both debug
                // values appear the cycle after the bus_err pulse.
                w_state_d    = c_ST_IDLE;
                w_err_addr_d = mem_addr;
                if (r_err_count_q != 16'hFFFF) begin
                    w_err_count_d = r_err_count_q + 16'd1;
                end
            end
            default: begin
                w_state_d = c_ST_IDLE;
                w_sel_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state_q     <= c_ST_IDLE;
            r_grant_q     <= '0;
            r_sel_q       <= '0;
            r_cnt_q       <= '0;
            r_err_count_q <= '0;
            r_err_addr_q  <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_grant_q     <= w_grant_d;
            r_sel_q       <= w_sel_d;
            r_cnt_q       <= w_cnt_d;
            r_err_count_q <= w_err_count_d;
            r_err_addr_q  <= w_err_addr_d;
        end
    end

    always_comb begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        case (r_state_q)
            c_ST_ACTIVE: begin
                mem_ready = w_gnt_ready;
                mem_rdata = w_gnt_rdata;
            end
            c_ST_ERR: begin
                mem_ready = 1'b1;
                mem_rdata = ERR_RDATA;
            end
            default: begin
                mem_ready = 1'b0;
                mem_rdata = '0;
            end
        endcase
    end

    assign bus_err   = (r_state_q == c_ST_ERR);
    assign s_sel     = r_sel_q;
    assign s_addr    = mem_addr;
    assign s_wdata   = mem_wdata;
    // Strobes are suppressed when nothing is selected, so dropped error
    // writes can never reach a slave.
    assign s_wstrb   = (|r_sel_q) ? mem_wstrb : 4'b0000;
    assign err_count = r_err_count_q;
    assign err_addr  = r_err_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_bus_decoder
// Purpose  : Directed self-checking bench for mem_bus_decoder (default slave
//            map, 8-cycle watchdog). Inputs change 1 time unit after the
//            rising edge and outputs are compared 2 units later.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_bus_decoder;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         mem_valid;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic [3:0]   mem_wstrb;
    logic         mem_ready;
    logic [31:0]  mem_rdata;
    logic [3:0]   s_sel;
    logic [31:0]  s_addr;
    logic [31:0]  s_wdata;
    logic [3:0]   s_wstrb;
    logic [3:0]   s_ready;
    logic [127:0] s_rdata;
    logic         bus_err;
    logic [15:0]  err_count;
    logic [31:0]  err_addr;

    int checks = 0;
    int errors = 0;

    mem_bus_decoder #(
        .NUM_SLAVES     (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .s_sel     (s_sel),
        .s_addr    (s_addr),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_ready   (s_ready),
        .s_rdata   (s_rdata),
        .bus_err   (bus_err),
        .err_count (err_count),
        .err_addr  (err_addr)
    );

    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        mem_valid = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        s_ready   = '0;
        s_rdata   = '0;

        // ---------------- reset state ----------------
        next_cycle();
        next_cycle();
        settle();
        chk("rst_sel",    32'(s_sel),     32'h0);
        chk("rst_ready",  32'(mem_ready), 32'h0);
        chk("rst_rdata",  mem_rdata,      32'h0);
        chk("rst_buserr", 32'(bus_err),   32'h0);
        chk("rst_errcnt", 32'(err_count), 32'h0);
        chk("rst_erradr", err_addr,       32'h0);
        reset_n = 1'b1;
        next_cycle();

        // ---------------- SRAM read, slave registers ready ----------------
        mem_valid = 1'b1; mem_addr = 32'h00000010; mem_wstrb = 4'b0000;
        settle();
        chk("rd_c0_sel",   32'(s_sel),     32'h0);
        chk("rd_c0_ready", 32'(mem_ready), 32'h0);
        next_cycle();
        settle();
        chk("rd_c1_sel",   32'(s_sel),     32'h1);
        chk("rd_c1_ready", 32'(mem_ready), 32'h0);
        next_cycle();
        s_ready = 4'b0001; s_rdata[0 +: 32] = 32'h12345678;
        settle();
        chk("rd_c2_ready", 32'(mem_ready), 32'h1);
        chk("rd_c2_rdata", mem_rdata,      32'h12345678);
        chk("rd_c2_err",   32'(bus_err),   32'h0);
        next_cycle();
        mem_valid = 1'b0; s_ready = '0; s_rdata = '0;
        settle();
        chk("rd_c3_sel",   32'(s_sel),     32'h0);
        chk("rd_c3_ready", 32'(mem_ready), 32'h0);
        chk("rd_c3_rdata", mem_rdata,      32'h0);

        // ---------------- write to 0x80000000 (slave 1 under this map) -----
        next_cycle();
        mem_valid = 1'b1; mem_addr = 32'h80000000; mem_wdata = 32'h3F; mem_wstrb = 4'b0001;
        settle();
        chk("wr_c0_wstrb", 32'(s_wstrb), 32'h0);
        next_cycle();
        s_ready = 4'b0100;              // spurious ready from a non-granted slave
        settle();
        chk("wr_c1_sel",   32'(s_sel),     32'h2);
        chk("wr_c1_addr",  s_addr,         32'h80000000);
        chk("wr_c1_wdata", s_wdata,        32'h3F);
        chk("wr_c1_wstrb", 32'(s_wstrb),   32'h1);
        chk("wr_c1_spur",  32'(mem_ready), 32'h0);
        next_cycle();
        s_ready = 4'b0110;
        settle();
        chk("wr_c2_ready", 32'(mem_ready), 32'h1);
        next_cycle();
        mem_valid = 1'b0; mem_wstrb = '0; mem_wdata = '0; s_ready = '0;
        settle();
        chk("wr_c3_sel",   32'(s_sel),     32'h0);

        // ---------------- unmapped read ----------------
        next_cycle();
        mem_valid = 1'b1; mem_addr = 32'h40000000;
        next_cycle();
        settle();
        chk("um_c1_sel",    32'(s_sel),     32'h0);
        chk("um_c1_ready",  32'(mem_ready), 32'h1);
        chk("um_c1_rdata",  mem_rdata,      32'hDEADBEEF);
        chk("um_c1_err",    32'(bus_err),   32'h1);
        chk("um_c1_cnt",    32'(err_count), 32'h0);
        next_cycle();
        mem_valid = 1'b0;
        settle();
        chk("um_c2_err",    32'(bus_err),   32'h0);
        chk("um_c2_cnt",    32'(err_count), 32'h1);
        chk("um_c2_addr",   err_addr,       32'h40000000);

        // ---------------- unmapped write: strobes never reach a slave -------
        next_cycle();
        mem_valid = 1'b1; mem_addr = 32'h40000100; mem_wdata = 32'h55; mem_wstrb = 4'b1111;
        next_cycle();
        settle();
        chk("uw_c1_wstrb", 32'(s_wstrb),   32'h0);
        chk("uw_c1_ready", 32'(mem_ready), 32'h1);
        next_cycle();
        mem_valid = 1'b0; mem_wstrb = '0;
        settle();
        chk("uw_c2_cnt",   32'(err_count), 32'h2);
        chk("uw_c2_addr",  err_addr,       32'h40000100);

        // ---------------- UART timeout ----------------
        next_cycle();
        mem_valid = 1'b1; mem_addr = 32'h8000000C;
        for (int k = 1; k <= 8; k++) begin
            next_cycle();
            settle();
            chk("to_sel",   32'(s_sel),     32'h4);
            chk("to_ready", 32'(mem_ready), 32'h0);
        end
        next_cycle();
        settle();
        chk("to_c9_sel",   32'(s_sel),     32'h0);
        chk("to_c9_ready", 32'(mem_ready), 32'h1);
        chk("to_c9_rdata", mem_rdata,      32'hDEADBEEF);
        chk("to_c9_err",   32'(bus_err),   32'h1);
        next_cycle();
        mem_valid = 1'b0;
        settle();
        chk("to_cnt",  32'(err_count), 32'h3);
        chk("to_addr", err_addr,       32'h8000000C);

        // ---------------- ready at the expiry cycle wins ----------------
        next_cycle();
        mem_valid = 1'b1; mem_addr = 32'h8000000C;
        for (int k = 1; k <= 7; k++) begin
            next_cycle();
        end
        next_cycle();
        s_ready = 4'b0100; s_rdata[64 +: 32] = 32'h5A5A0008;
        settle();
        chk("race_sel",   32'(s_sel),     32'h4);
        chk("race_ready", 32'(mem_ready), 32'h1);
        chk("race_rdata", mem_rdata,      32'h5A5A0008);
        chk("race_err",   32'(bus_err),   32'h0);
        next_cycle();
        mem_valid = 1'b0; s_ready = '0; s_rdata = '0;
        settle();
        chk("race_cnt",  32'(err_count), 32'h3);
        chk("race_err2", 32'(bus_err),   32'h0);

        // ---------------- error counter saturation ----------------
        // Preload just below the ceiling instead of issuing 65k accesses.
        next_cycle();
        force dut.r_err_count_q = 16'hFFFE;
        #1;
        release dut.r_err_count_q;
        next_cycle();
        mem_valid = 1'b1; mem_addr = 32'h40000004;
        next_cycle();
        next_cycle();
        mem_valid = 1'b0;
        settle();
        chk("sat_cnt1", 32'(err_count), 32'hFFFF);
        next_cycle();
        mem_valid = 1'b1; mem_addr = 32'h40000008;
        next_cycle();
        settle();
        chk("sat_err", 32'(bus_err), 32'h1);
        next_cycle();
        mem_valid = 1'b0;
        settle();
        chk("sat_cnt2",  32'(err_count), 32'hFFFF);
        chk("sat_addr",  err_addr,       32'h40000008);

        // ---------------- reset during ACTIVE ----------------
        next_cycle();
        mem_valid = 1'b1; mem_addr = 32'h00000010;
        next_cycle();
        settle();
        chk("ra_sel", 32'(s_sel), 32'h1);
        reset_n = 1'b0; mem_valid = 1'b0; mem_addr = '0;
        next_cycle();
        settle();
        chk("ra_sel0",   32'(s_sel),     32'h0);
        chk("ra_ready",  32'(mem_ready), 32'h0);
        chk("ra_rdata",  mem_rdata,      32'h0);
        chk("ra_buserr", 32'(bus_err),   32'h0);
        chk("ra_cnt",    32'(err_count), 32'h0);
        chk("ra_addr",   err_addr,       32'h0);
        reset_n = 1'b1;
        next_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
